mac_layer_seq: RTL and testbench

- Sequences one fully-connected layer on the shared 8x8 signed MAC.
- Per output neuron: clears the accumulator, streams N_IN input/weight ROM addresses into the MAC, lets the saturated accumulator address the activation LUT, then writes the LUT result to the output RAM.
- Sits between the top-level control FSM (start/done) and the MAC, input RAM, weight ROM, activation LUT ROM and output RAM.
- All memories are synchronous-read with 1-cycle latency.

---
 rtl/mac_layer_seq.sv | 104 ++++++++++
 tb/tb_mac_layer_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_layer_seq.sv
// Fully-connected layer sequencer: drives the shared MAC, its input/weight ROM
// addresses, the activation LUT timing and the output RAM write, one neuron at a time.
module mac_layer_seq #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 32,
    localparam int IW = $clog2(N_IN),
    localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int WW = $clog2(N_IN * N_OUT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] in_addr,
    output logic [WW-1:0] wt_addr,
    output logic          mac_clr_n,
    output logic          out_we,
    output logic [OW-1:0] out_addr
);

    typedef enum logic [2:0] {IDLE, CLR, ACC, LUT, WR} state_t;

    localparam logic [IW-1:0] LAST_IN  = IW'(N_IN - 1);
    localparam logic [OW-1:0] LAST_OUT = OW'(N_OUT - 1);
    localparam logic [WW-1:0] STRIDE   = WW'(N_IN);

    state_t        state, state_n;
    logic [IW-1:0] cnt, cnt_n;
    logic [IW-1:0] in_addr_n;
    logic [OW-1:0] neuron, neuron_n;
    logic [WW-1:0] base, base_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            in_addr <= '0;
            neuron  <= '0;
            base    <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            in_addr <= in_addr_n;
            neuron  <= neuron_n;
            base    <= base_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        in_addr_n = in_addr;
        neuron_n  = neuron;
        base_n    = base;
        unique case (state)
            IDLE: begin
                cnt_n     = '0;
                in_addr_n = '0;
                neuron_n  = '0;
                base_n    = '0;
                if (start) state_n = CLR;
            end
            CLR: begin
                // ROM latency: the address issued one cycle ahead of the data index
                state_n   = ACC;
                cnt_n     = '0;
                in_addr_n = IW'(1);
            end
            ACC: begin
                if (cnt == LAST_IN) begin
                    state_n   = LUT;
                    cnt_n     = '0;
                    in_addr_n = '0;
                end else begin
                    cnt_n = cnt + IW'(1);
                    if (in_addr != LAST_IN) in_addr_n = in_addr + IW'(1);
                end
            end
            LUT: state_n = WR;
            WR: begin
                if (neuron == LAST_OUT) begin
                    state_n  = IDLE;
                    neuron_n = '0;
                    base_n   = '0;
                end else begin
                    state_n  = CLR;
                    neuron_n = neuron + OW'(1);
                    base_n   = base + STRIDE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs decode from registered state only, so reset clears them asynchronously
    assign busy      = (state != IDLE);
    assign mac_clr_n = (state == ACC);
    assign out_we    = (state == WR);
    assign done      = (state == WR) && (neuron == LAST_OUT);
    assign out_addr  = neuron;
    assign wt_addr   = base + WW'(in_addr);

endmodule

// File: tb/tb_mac_layer_seq.sv
// Bench for mac_layer_seq: behavioural ROM/MAC/LUT around the sequencer, with a
// scoreboard of expected output-RAM writes.
module tb_mac_layer_seq;

    localparam int NI = 4;
    localparam int NO = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0, busy, done, mac_clr_n, out_we;
    logic [1:0] in_addr;
    logic [2:0] wt_addr;
    logic [0:0] out_addr;

    logic       start_e = 1'b0, busy_e, done_e, mac_clr_n_e, out_we_e;
    logic [0:0] in_addr_e, wt_addr_e, out_addr_e;

    logic        start_b = 1'b0, busy_b, done_b, mac_clr_n_b, out_we_b;
    logic [9:0]  in_addr_b;
    logic [14:0] wt_addr_b;
    logic [4:0]  out_addr_b;

    mac_layer_seq #(.N_IN(NI), .N_OUT(NO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_addr(in_addr), .wt_addr(wt_addr), .mac_clr_n(mac_clr_n),
        .out_we(out_we), .out_addr(out_addr)
    );

    mac_layer_seq #(.N_IN(2), .N_OUT(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .start(start_e), .busy(busy_e), .done(done_e),
        .in_addr(in_addr_e), .wt_addr(wt_addr_e), .mac_clr_n(mac_clr_n_e),
        .out_we(out_we_e), .out_addr(out_addr_e)
    );

    mac_layer_seq #(.N_IN(784), .N_OUT(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .in_addr(in_addr_b), .wt_addr(wt_addr_b), .mac_clr_n(mac_clr_n_b),
        .out_we(out_we_b), .out_addr(out_addr_b)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [0:0] addr;
        logic [9:0] data;
    } exp_t;
    exp_t sb[$];

    function automatic logic [9:0] sat10(input int v);
        if (v < 0) return 10'd0;
        if (v > 1023) return 10'h3FF;
        return 10'(v);
    endfunction

    // Memory/MAC/LUT model: 1-cycle ROM reads, identity LUT over a saturated accumulator
    logic signed [7:0]  in_mem [NI];
    logic signed [7:0]  wt_mem [NI*NO];
    logic signed [7:0]  a_q = '0, b_q = '0;
    logic signed [31:0] acc = '0, acc_b = '0;
    logic [9:0]         lut_q = '0, lut_b = '0;

    always @(posedge clk) begin
        a_q   <= in_mem[in_addr];
        b_q   <= wt_mem[wt_addr];
        acc   <= mac_clr_n ? acc + a_q * b_q : 32'sd0;
        lut_q <= sat10(acc);
        acc_b <= mac_clr_n_b ? acc_b + 32'sd16129 : 32'sd0;
        lut_b <= sat10(acc_b);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, mac_clr_n, out_we} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 0000", {busy, done, mac_clr_n, out_we});
        end
        vectors++;
        if ({in_addr, wt_addr, out_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_addr: in=%0d wt=%0d out=%0d want 0", in_addr, wt_addr, out_addr);
        end
        vectors++;
        if ({busy_e, done_e, mac_clr_n_e, out_we_e, in_addr_e, wt_addr_e} !== '0) begin
            miscompares++;
            $display("FAIL reset_edge_cfg: got %b want 0",
                     {busy_e, done_e, mac_clr_n_e, out_we_e, in_addr_e, wt_addr_e});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_layer(input bit ones);
        int p, n, s, v, ai;
        for (int i = 0; i < NI; i++) begin
            v = ones ? 1 : int'($urandom_range(0, 30)) - 10;
            in_mem[i] = 8'(v);
        end
        for (int i = 0; i < NI*NO; i++) begin
            v = ones ? 1 : int'($urandom_range(0, 30)) - 10;
            wt_mem[i] = 8'(v);
        end
        for (int k = 0; k < NO; k++) begin
            s = 0;
            for (int i = 0; i < NI; i++) s += int'(in_mem[i]) * int'(wt_mem[k*NI + i]);
            if (ones) s = 4;
            sb.push_back('{addr: 1'(k), data: sat10(s)});
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            p = (cyc - 1) % 7;
            n = (cyc - 1) / 7;
            vectors++;
            if ({busy, done, out_we} !== {cyc <= 14, cyc == 14, cyc <= 14 && p == 6}) begin
                miscompares++;
                $display("FAIL layer_ctrl c%0d: busy/done/we=%b%b%b want %b%b%b", cyc, busy, done,
                         out_we, cyc <= 14, cyc == 14, cyc <= 14 && p == 6);
            end
            vectors++;
            if (mac_clr_n !== (cyc <= 14 && p >= 1 && p <= 4)) begin
                miscompares++;
                $display("FAIL layer_clr c%0d: mac_clr_n=%b", cyc, mac_clr_n);
            end
            if (cyc <= 14 && p <= 4) begin
                ai = (p == 0) ? 0 : (p > 3 ? 3 : p);
                vectors++;
                if (in_addr !== 2'(ai) || wt_addr !== 3'(n*NI + ai)) begin
                    miscompares++;
                    $display("FAIL layer_addr c%0d: in=%0d wt=%0d want in=%0d wt=%0d",
                             cyc, in_addr, wt_addr, ai, n*NI + ai);
                end
            end
            if (out_we) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL layer_extra_write c%0d: out_we with empty scoreboard", cyc);
                end else begin
                    exp_t e = sb.pop_front();
                    if (out_addr !== e.addr || lut_q !== e.data) begin
                        miscompares++;
                        $display("FAIL layer_write c%0d: addr=%0d data=%0d want addr=%0d data=%0d",
                                 cyc, out_addr, lut_q, e.addr, e.data);
                    end
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL layer_missing_write: %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_start_while_busy();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            vectors++;
            if ({busy, done} !== {cyc <= 14, cyc == 14}) begin
                miscompares++;
                $display("FAIL busy_ignore c%0d: busy/done=%b%b want %b%b", cyc, busy, done,
                         cyc <= 14, cyc == 14);
            end
            start = (cyc == 3 || cyc == 10 || cyc == 14);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_start_held();
        int we_count = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 44; cyc++) begin
            if (out_we) we_count++;
            vectors++;
            if ({busy, done} !== {cyc % 15 != 0, cyc % 15 == 14}) begin
                miscompares++;
                $display("FAIL held_start c%0d: busy/done=%b%b want %b%b", cyc, busy, done,
                         cyc % 15 != 0, cyc % 15 == 14);
            end
            if (cyc == 44) start = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if (we_count != 6 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL held_writes: we=%0d busy=%b want 6 and 0", we_count, busy);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        vectors++;
        if ({mac_clr_n, out_addr} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_pre: clr/out_addr=%b want 11", {mac_clr_n, out_addr});
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, mac_clr_n, out_we, in_addr, wt_addr, out_addr} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got %b want 0",
                     {busy, done, mac_clr_n, out_we, in_addr, wt_addr, out_addr});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({busy, out_we} !== 2'b00) begin
                miscompares++;
                $display("FAIL mid_hold: busy/we=%b want 00", {busy, out_we});
            end
        end
        rst_n = 1'b1;
        test_layer(1'b0);
    endtask

    task automatic test_edge_config();
        logic [0:0] exp_a [3];
        exp_a[0] = 1'b0; exp_a[1] = 1'b1; exp_a[2] = 1'b1;
        @(negedge clk) start_e = 1'b1;
        @(negedge clk) start_e = 1'b0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            vectors++;
            if ({busy_e, done_e, out_we_e, mac_clr_n_e} !==
                {cyc <= 5, cyc == 5, cyc == 5, cyc == 2 || cyc == 3}) begin
                miscompares++;
                $display("FAIL edge_ctrl c%0d: busy/done/we/clr=%b", cyc,
                         {busy_e, done_e, out_we_e, mac_clr_n_e});
            end
            if (cyc <= 3) begin
                vectors++;
                if (in_addr_e !== exp_a[cyc-1] || wt_addr_e !== exp_a[cyc-1]) begin
                    miscompares++;
                    $display("FAIL edge_addr c%0d: in=%0d wt=%0d want %0d", cyc, in_addr_e,
                             wt_addr_e, exp_a[cyc-1]);
                end
            end
            if (out_we_e) begin
                vectors++;
                if (out_addr_e !== 1'b0) begin
                    miscompares++;
                    $display("FAIL edge_out_addr: got %0d want 0", out_addr_e);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturate();
        int hit = 0;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        for (int cyc = 1; cyc <= 1000 && hit == 0; cyc++) begin
            if (out_we_b) hit = cyc;
            else @(negedge clk);
        end
        vectors++;
        if (hit != 787) begin
            miscompares++;
            $display("FAIL sat_latency: first out_we at cycle %0d want 787", hit);
        end
        vectors++;
        if (out_addr_b !== 5'd0 || lut_b !== 10'h3FF) begin
            miscompares++;
            $display("FAIL sat_lut: addr=%0d lut=%h want 0 and 3ff", out_addr_b, lut_b);
        end
    endtask

    initial begin
        test_reset();
        test_layer(1'b1);
        test_layer(1'b0);
        test_start_while_busy();
        test_start_held();
        test_reset_mid();
        test_edge_config();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
